instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/key_edge.sv | 41 ++++
 rtl/instr_fetch.sv | 194 +++++++++++++++++++
 tb/tb_instr_fetch.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch block.
//   * Default widths for the data/PC word, the instruction-memory address and
//     the signed branch offset.
//   * Width of the accepted-instruction counter.
//   * The fetch FSM state encoding. It is also exported on a debug port so that
//     checkers can follow the sequencer directly.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int DEF_WORD_SIZE   = 16;
    localparam int DEF_MEM_SIZE    = 8;
    localparam int DEF_OFFSET_SIZE = 4;
    localparam int TIMER_W         = 4;

    // Fetch sequencer states:
    //   ST_IDLE  : waiting for run_mode or a pending single-step request
    //   ST_FETCH : address cycle, the ROM samples imem_addr at the end of it
    //   ST_WAIT  : ROM data is on imem_rdata, captured into instr at the end
    //   ST_VALID : instr is presented downstream until it is accepted
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_VALID = 2'd3
    } fetch_state_t;

endpackage : fetch_pkg

// File: rtl/key_edge.sv
// -----------------------------------------------------------------------------
// key_edge
// Brings the asynchronous step key into the clk domain and produces a
// one-cycle pulse on each rising edge of the synchronised key level.
//
// Ports
//   clk     in   1  system clock
//   rst     in   1  synchronous active-high reset, clears all three flops
//   i_key   in   1  asynchronous key level (active-high)
//   o_rise  out  1  single-cycle pulse on a rising edge of the synchronised key
// -----------------------------------------------------------------------------
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_rise
);

    // r_sync1/r_sync2 form the two-flop synchroniser. r_prev holds the
    // synchronised level from the previous cycle for edge detection.
    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Built only from flop outputs, so the pulse is glitch-free and exactly
    // one clock long for each low-to-high transition of the key.
    assign o_rise = r_sync2 & ~r_prev;

endmodule : key_edge

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction-fetch stage. The sequencer holds the program counter, reads an
// external synchronous ROM and presents each fetched instruction downstream
// through a valid/ready handshake.
//
// Handshake: instr_valid is high exactly while the sequencer is in ST_VALID.
// A transfer ("accept") happens on a rising clock edge where instr_valid and
// instr_ready are both 1. While instr_valid=1 and instr_ready=0, instr,
// pc_counter and timer hold their values. instr_valid never drops without an
// accept, except when load_pc or rst is applied.
//
// Parameters
//   WORD_SIZE    data / PC / instruction width
//   MEM_SIZE     instruction-memory address width (low bits of the PC)
//   OFFSET_SIZE  two's-complement branch-offset width
//
// Ports
//   clk           in   1            single clock, rising-edge
//   rst           in   1            synchronous active-high reset
//   key_ok        in   1            asynchronous single-step key
//   run_mode      in   1            1 = free-run, 0 = one fetch per key press
//   load_pc       in   1            load PC from data_in and abandon any fetch
//   data_in       in   WORD_SIZE    PC load value
//   branch_taken  in   1            add offset to the PC on accept
//   offset        in   OFFSET_SIZE  signed branch offset
//   imem_addr     out  MEM_SIZE     ROM address (= pc_counter[MEM_SIZE-1:0])
//   imem_rdata    in   WORD_SIZE    ROM data, one cycle after the address
//   instr         out  WORD_SIZE    fetched instruction
//   instr_valid   out  1            instr holds a valid instruction
//   instr_ready   in   1            downstream accepts instr
//   pc_counter    out  WORD_SIZE    current program counter
//   timer         out  4            accepted-instruction count, mod 16
//   dbg_state     out  2            current sequencer state (debug)
// -----------------------------------------------------------------------------
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int WORD_SIZE   = DEF_WORD_SIZE,
    parameter int MEM_SIZE    = DEF_MEM_SIZE,
    parameter int OFFSET_SIZE = DEF_OFFSET_SIZE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_ok,
    input  logic                   run_mode,
    input  logic                   load_pc,
    input  logic [WORD_SIZE-1:0]   data_in,
    input  logic                   branch_taken,
    input  logic [OFFSET_SIZE-1:0] offset,
    output logic [MEM_SIZE-1:0]    imem_addr,
    input  logic [WORD_SIZE-1:0]   imem_rdata,
    output logic [WORD_SIZE-1:0]   instr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [WORD_SIZE-1:0]   pc_counter,
    output logic [TIMER_W-1:0]     timer,
    output fetch_state_t           dbg_state
);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    fetch_state_t           r_state;
    logic [WORD_SIZE-1:0]   r_pc;
    logic [WORD_SIZE-1:0]   r_instr;
    logic                   r_instr_valid;
    logic [TIMER_W-1:0]     r_timer;
    logic                   r_step_pending;

    // -------------------------------------------------------------------------
    // Wires
    // -------------------------------------------------------------------------
    logic                   w_key_rise;
    logic                   w_accept;
    logic                   w_idle_go;
    logic [WORD_SIZE-1:0]   w_offset_ext;
    logic [WORD_SIZE-1:0]   w_pc_next;

    // -------------------------------------------------------------------------
    // Step-key synchroniser and edge detector
    // -------------------------------------------------------------------------
    key_edge u_key_edge (
        .clk    (clk),
        .rst    (rst),
        .i_key  (key_ok),
        .o_rise (w_key_rise)
    );

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    assign w_accept = r_instr_valid & instr_ready;

    // IDLE leaves for FETCH only when nothing with higher priority (load_pc)
    // is pulling the sequencer back to IDLE in the same cycle.
    assign w_idle_go = (r_state == ST_IDLE) && (run_mode || r_step_pending)
                       && !load_pc;

    // Sign-extend the branch offset to the full PC width.
    assign w_offset_ext = {{(WORD_SIZE-OFFSET_SIZE){offset[OFFSET_SIZE-1]}},
                           offset};

    // Next sequential PC. The adder width equals WORD_SIZE, so the result
    // wraps naturally modulo 2^WORD_SIZE in both directions.
    always_comb begin
        w_pc_next = r_pc + WORD_SIZE'(1);
        if (branch_taken) begin
            w_pc_next = r_pc + WORD_SIZE'(1) + w_offset_ext;
        end
    end

    // -------------------------------------------------------------------------
    // Single-step request
    // A key edge sets the request and the IDLE->FETCH transition consumes it.
    // Any number of edges before that transition collapse into one request.
    // An edge arriving on the same cycle as the transition belongs to the
    // next step, so the set takes precedence over the clear.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_pending <= 1'b0;
        end else if (w_key_rise) begin
            r_step_pending <= 1'b1;
        end else if (w_idle_go) begin
            r_step_pending <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Fetch sequencer: state, PC, instruction register, valid flag and
    // accept counter are all updated together in this one block.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_pc          <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_timer       <= '0;
        end else if (load_pc) begin
            // A PC load abandons whatever is in flight, including an
            // instruction currently being accepted. The timer keeps its value.
            r_pc          <= data_in;
            r_state       <= ST_IDLE;
            r_instr_valid <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_idle_go) begin
                        r_state <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    // imem_addr is stable during this cycle and the ROM
                    // registers it at the closing edge.
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    r_instr       <= imem_rdata;
                    r_instr_valid <= 1'b1;
                    r_state       <= ST_VALID;
                end

                ST_VALID: begin
                    if (w_accept) begin
                        r_pc          <= w_pc_next;
                        r_timer       <= r_timer + TIMER_W'(1);
                        r_instr_valid <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end

                default: begin
                    r_state       <= ST_IDLE;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign imem_addr   = r_pc[MEM_SIZE-1:0];
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc_counter  = r_pc;
    assign timer       = r_timer;
    assign dbg_state   = r_state;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam int W  = 16;
    localparam int M  = 8;
    localparam int O  = 4;
    localparam int EW = 2*W + 4;   // {instr, pc, timer}

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic           clk = 1'b0;
    logic           rst;
    logic           key_ok;
    logic           run_mode;
    logic           load_pc;
    logic [W-1:0]   data_in;
    logic           branch_taken;
    logic [O-1:0]   offset;
    logic [M-1:0]   imem_addr;
    logic [W-1:0]   imem_rdata;
    logic [W-1:0]   instr;
    logic           instr_valid;
    logic           instr_ready;
    logic [W-1:0]   pc_counter;
    logic [3:0]     timer;
    fetch_state_t   dbg_state;

    always #5 clk = ~clk;

    instr_fetch #(.WORD_SIZE(W), .MEM_SIZE(M), .OFFSET_SIZE(O)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_ok       (key_ok),
        .run_mode     (run_mode),
        .load_pc      (load_pc),
        .data_in      (data_in),
        .branch_taken (branch_taken),
        .offset       (offset),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .pc_counter   (pc_counter),
        .timer        (timer),
        .dbg_state    (dbg_state)
    );

    // External synchronous ROM: ROM[a] = a + 16'h1000
    logic [W-1:0] rom [0:(1<<M)-1];
    initial begin
        for (int i = 0; i < (1<<M); i++) rom[i] = W'(16'h1000 + i);
    end
    always @(posedge clk) imem_rdata <= rom[imem_addr];

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    logic [W-1:0]  m_pc;
    logic [3:0]    m_timer;
    bit            cur_bt;
    logic [O-1:0]  cur_off;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    // PC after an accepted instruction, in plain integer arithmetic mod 2^W.
    function automatic logic [W-1:0] next_pc(input logic [W-1:0] pc, input bit bt,
                                             input logic [O-1:0] off);
        int delta;
        delta = bt ? int'($signed(off)) : 0;
        return W'(int'(pc) + 1 + delta);
    endfunction

    // Monitor: checks the ROM address every cycle, checks every valid cycle
    // against the head expectation, and pops it on a real accept.
    always @(negedge clk) begin
        if (!rst) begin
            check("imem_addr", 32'(imem_addr), 32'(m_pc[M-1:0]));
            if (instr_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_valid");
                end else begin
                    mon_e = exp_q[0];
                    check("instr", 32'(instr), 32'(mon_e[EW-1 -: W]));
                    check("pc_in_valid", 32'(pc_counter), 32'(mon_e[W+3 -: W]));
                    check("timer_in_valid", 32'(timer), 32'(mon_e[3:0]));
                    if (instr_ready && !load_pc) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (drive at posedge+1)
    // ------------------------------------------------------------------
    task automatic expect_instr(input bit bt, input logic [O-1:0] off);
        cur_bt       = bt;
        cur_off      = off;
        branch_taken = bt;
        offset       = off;
        exp_q.push_back({rom[m_pc[M-1:0]], m_pc, m_timer});
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!instr_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!instr_valid) fail_now("wait_valid_timeout");
    endtask

    task automatic wait_state(input fetch_state_t st);
        int n = 0;
        while (dbg_state != st && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_state", 32'(dbg_state), 32'(st));
    endtask

    task automatic accept_now();
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        m_pc    = next_pc(m_pc, cur_bt, cur_off);
        m_timer = m_timer + 4'd1;
        check("pc_after_accept", 32'(pc_counter), 32'(m_pc));
        check("timer_after_accept", 32'(timer), 32'(m_timer));
        check("valid_after_accept", 32'(instr_valid), 32'd0);
    endtask

    task automatic do_instr(input bit bt, input logic [O-1:0] off, input int stall,
                            output int lat);
        expect_instr(bt, off);
        wait_valid(lat);
        repeat (stall) begin
            @(posedge clk); #1;
        end
        accept_now();
    endtask

    task automatic load(input logic [W-1:0] v);
        load_pc = 1'b1;
        data_in = v;
        @(posedge clk); #1;
        load_pc = 1'b0;
        m_pc    = v;
        check("pc_after_load", 32'(pc_counter), 32'(v));
        check("valid_after_load", 32'(instr_valid), 32'd0);
        check("timer_after_load", 32'(timer), 32'(m_timer));
    endtask

    task automatic key_pulse();
        key_ok = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        key_ok = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int lat;
        int guard;
        rst = 1'b1; key_ok = 1'b0; run_mode = 1'b1; load_pc = 1'b0;
        data_in = '0; branch_taken = 1'b0; offset = '0; instr_ready = 1'b0;
        m_pc = '0; m_timer = '0; cur_bt = 1'b0; cur_off = '0;

        // Reset state
        repeat (3) begin @(posedge clk); #1; end
        check("rst_pc", 32'(pc_counter), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_timer", 32'(timer), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_addr", 32'(imem_addr), 32'd0);
        rst = 1'b0;

        // Free-run: 1000,1001,1002 with 3-cycle latency, timer=3
        for (int i = 0; i < 3; i++) begin
            do_instr(1'b0, '0, 0, lat);
            check("latency", 32'(lat), 32'd3);
        end
        check("timer_after_three", 32'(timer), 32'd3);

        // Load during WAIT discards the fetch; next instruction is ROM[3]
        wait_state(ST_WAIT);
        load(16'h0003);
        do_instr(1'b0, '0, 2, lat);

        // Branches from pc=4: -2 -> 3, +7 -> 12
        load(16'h0004);
        do_instr(1'b1, 4'b1110, 0, lat);
        load(16'h0004);
        do_instr(1'b1, 4'b0111, 0, lat);

        // Backpressure for 5 cycles, accept on the 6th
        do_instr(1'b0, '0, 5, lat);

        // Randomized traffic
        for (int i = 0; i < 25; i++) begin
            do_instr(1'($urandom_range(0, 1)), O'($urandom_range(0, 15)),
                     int'($urandom_range(0, 3)), lat);
        end

        // Load coincident with accept: load wins, no increment, timer unchanged
        expect_instr(1'b0, '0);
        wait_valid(lat);
        load_pc = 1'b1; data_in = 16'h0040; instr_ready = 1'b1;
        @(posedge clk); #1;
        load_pc = 1'b0; instr_ready = 1'b0;
        m_pc = 16'h0040;
        void'(exp_q.pop_front());
        check("ld_acc_pc", 32'(pc_counter), 32'h40);
        check("ld_acc_timer", 32'(timer), 32'(m_timer));
        check("ld_acc_valid", 32'(instr_valid), 32'd0);

        // Bring timer to 15, then PC FFFF wraps to 0 and timer wraps to 0
        guard = 0;
        while (m_timer != 4'd15 && guard < 20) begin
            do_instr(1'($urandom_range(0, 1)), O'($urandom_range(0, 15)), 0, lat);
            guard++;
        end
        check("timer_at_15", 32'(timer), 32'd15);
        load(16'hFFFF);
        do_instr(1'b0, '0, 0, lat);
        check("wrap_pc", 32'(pc_counter), 32'd0);
        check("wrap_addr", 32'(imem_addr), 32'd0);
        check("wrap_timer", 32'(timer), 32'd0);

        // Single-step: run_mode drops mid-fetch, three key presses while busy
        expect_instr(1'b0, '0);
        @(posedge clk); #1;
        check("step_in_fetch", 32'(dbg_state), 32'(ST_FETCH));
        run_mode = 1'b0;
        repeat (3) key_pulse();
        wait_valid(lat);
        accept_now();
        expect_instr(1'b0, '0);
        wait_valid(lat);
        check("step_latency", 32'(lat), 32'd3);
        accept_now();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("step_idle_state", 32'(dbg_state), 32'(ST_IDLE));
            check("step_idle_valid", 32'(instr_valid), 32'd0);
        end
        expect_instr(1'b1, 4'b1111);
        key_pulse();
        wait_valid(lat);
        accept_now();
        repeat (10) begin @(posedge clk); #1; end
        check("one_step_idle", 32'(dbg_state), 32'(ST_IDLE));

        // Reset mid-fetch overrides a simultaneous load and discards the fetch
        run_mode = 1'b1;
        wait_state(ST_WAIT);
        rst = 1'b1; load_pc = 1'b1; data_in = 16'h0055;
        @(posedge clk); #1;
        m_pc = '0; m_timer = '0;
        check("midrst_pc", 32'(pc_counter), 32'd0);
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_timer", 32'(timer), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0; load_pc = 1'b0;
        do_instr(1'b0, '0, 0, lat);
        check("post_rst_latency", 32'(lat), 32'd3);

        repeat (2) begin @(posedge clk); #1; end
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule : tb_instr_fetch
